// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> DONE, one access in flight.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0] state;
  logic       win;       // port ID of the access in flight
  logic       we_q;      // latched direction of the access in flight
  logic       win_next;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last;            // port that won the most recent grant

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == IDLE && (req0 || req1)) begin
      last <= win_next;
    end
  end
`endif

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    win_next = 1'b0;
    if (req0 && req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      win_next = ~last;
`else
      win_next = 1'b0;
`endif
    end else if (req1) begin
      win_next = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      win       <= 1'b0;
      we_q      <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      // Pulse outputs default low; only the state entered this edge raises one.
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            win       <= win_next;
            we_q      <= win_next ? we1 : we0;
            mem_we    <= win_next ? we1 : we0;
            mem_addr  <= win_next ? addr1 : addr0;
            mem_wdata <= win_next ? wdata1 : wdata0;
            gnt0      <= ~win_next;
            gnt1      <= win_next;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (win) rdata1 <= mem_rdata;
            else     rdata0 <= mem_rdata;
          end
          done0 <= ~win;
          done1 <= win;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 8, data memory address width.
REQ-002 Parameter DW, default 8, data memory word width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  access request from requester 0 / 1; held high until that requester's gnt is seen.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; qualified by req.
REQ-007 addr0, addr1  input  AW each  access address.
REQ-008 wdata0, wdata1  input  DW each  write data.
REQ-009 gnt0, gnt1  output  1 each  registered, one-cycle pulse: request accepted.
REQ-010 done0, done1  output  1 each  registered, one-cycle pulse: access complete.
REQ-011 rdata0, rdata1  output  DW each  registered read data; valid when done is high after a read, held until that port's next read completes.
REQ-012 mem_we  output  1  write enable to the data memory.
REQ-013 mem_addr  output  AW  address to the data memory.
REQ-014 mem_wdata  output  DW  write data to the data memory.
REQ-015 mem_rdata  input  DW  combinational read data from the data memory.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE; one access in flight at a time.
REQ-017 IDLE: no req -> stay IDLE; any req -> select winner, latch its we/addr/wdata and winner ID, go to ACCESS.
REQ-018 ACCESS lasts exactly one cycle: gnt of the winner is high, mem_addr/mem_wdata driven from latched values, mem_we = latched we.
REQ-019 At the ACCESS->DONE edge, a read captures mem_rdata into the winner's rdata; a write leaves both rdata unchanged.
REQ-020 DONE lasts exactly one cycle: winner's done high; then IDLE.
REQ-021 Latency: req sampled at edge N -> gnt high cycle N+1 -> done (and rdata valid) high cycle N+2; peak throughput one access per 3 cycles.
REQ-022 Requests arriving while not in IDLE are not accepted until the next IDLE; no request is dropped while its req stays high.
REQ-023 Single requester: that requester always wins.
REQ-024 mem_we is 0 in IDLE and DONE; memory writes occur only on the edge ending ACCESS.
REQ-025 Outside ACCESS mem_addr and mem_wdata hold their latched values.
REQ-026 gnt0 and gnt1 are never high together; likewise done0 and done1.
REQ-027 Requester inputs are sampled only in IDLE; changes at other times have no effect on the in-flight access.

Reset
REQ-028 rst high forces state IDLE; gnt0, gnt1, done0, done1 and mem_we to 0; mem_addr, mem_wdata, rdata0 and rdata1 to 0; last-winner pointer to 1 (port 0 wins the first tie).
REQ-029 rst asserted mid-access aborts it: no memory write completes, no done pulse is issued, and arbitration restarts from IDLE after release.

Configuration
REQ-030 Macro DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the port that did not win last is granted; the last-winner pointer is updated on every grant.
REQ-031 Macro DMEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins ties; the pointer logic is absent.

Verification
REQ-032 After reset, req0=1, we0=1, addr0=8'h10, wdata0=8'hA5 -> gnt0 at cycle N+1 with mem_we=1, mem_addr=8'h10; done0 at N+2; a memory model shows [8'h10]=8'hA5.
REQ-033 Then req1=1, we1=0, addr1=8'h10 -> gnt1 at N+1 with mem_we=0; done1 at N+2 with rdata1=8'hA5; rdata0 unchanged.
REQ-034 req0 and req1 held high with reads to 8'h01 and 8'h02 -> with round robin: grants 0,1,0,1 one access per 3 cycles; without the macro: port 0 only while req0 stays high.
REQ-035 rst pulsed during ACCESS of a write to 8'h20 with wdata 8'h5A -> [8'h20] unchanged, no done, all outputs 0, next request is served normally.
REQ-036 addr0 changed from 8'h30 to 8'h31 during ACCESS -> mem_addr stays 8'h30 for the whole access.
